// File: rtl/adim_toplayici.sv
// Dial-step collector for the two-lock combination checker: counts right/left steps
// for lock A then lock B. Optional inactivity timeout enabled by `define ADIM_ZAMAN_ASIMI_EN.
module adim_toplayici #(
  parameter int unsigned SAG_MAX     = 7,
  parameter int unsigned SOL_MAX     = 3
`ifdef ADIM_ZAMAN_ASIMI_EN
  ,
  parameter int unsigned ZAMAN_ASIMI = 1000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sag_tus,
  input  logic       sol_tus,
  input  logic       onay_tus,
  input  logic       iptal,
  output logic [5:0] sag_adimlar,
  output logic [3:0] sol_adimlar,
  output logic       gecerli,
  output logic [2:0] asama
);

  typedef enum logic [2:0] {
    BOS   = 3'd0,
    A_SAG = 3'd1,
    A_SOL = 3'd2,
    B_SAG = 3'd3,
    B_SOL = 3'd4,
    HAZIR = 3'd5
  } durum_e;

  typedef struct packed {
    logic [2:0] a_sag;
    logic [1:0] a_sol;
    logic [2:0] b_sag;
    logic [1:0] b_sol;
  } sayac_t;

  durum_e durum_q;
  sayac_t say_q;
  logic   gecerli_q;
  logic   sag_q, sol_q, onay_q;

  logic sag_kenar, sol_kenar, onay_kenar, herhangi_kenar;

  assign sag_kenar      = sag_tus  & ~sag_q;
  assign sol_kenar      = sol_tus  & ~sol_q;
  assign onay_kenar     = onay_tus & ~onay_q;
  assign herhangi_kenar = sag_kenar | sol_kenar | onay_kenar;

  function automatic logic [2:0] sag_art(input logic [2:0] v);
    return (32'(v) >= SAG_MAX) ? v : 3'(v + 3'd1);
  endfunction

  function automatic logic [1:0] sol_art(input logic [1:0] v);
    return (32'(v) >= SOL_MAX) ? v : 2'(v + 2'd1);
  endfunction

`ifdef ADIM_ZAMAN_ASIMI_EN
  localparam logic [19:0] ZAMAN_SON = 20'(ZAMAN_ASIMI - 1);
  logic [19:0] zaman_q;
  logic        aktif;
  assign aktif = (durum_q == A_SAG) || (durum_q == A_SOL) ||
                 (durum_q == B_SAG) || (durum_q == B_SOL);
`endif

  // NOTE: all state uses non-blocking assignments; later assignments in this block
  // deliberately override earlier ones (timeout beats normal stepping).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q   <= BOS;
      say_q     <= '0;
      gecerli_q <= 1'b0;
      sag_q     <= 1'b0;
      sol_q     <= 1'b0;
      onay_q    <= 1'b0;
`ifdef ADIM_ZAMAN_ASIMI_EN
      zaman_q   <= '0;
`endif
    end else begin
      sag_q  <= sag_tus;
      sol_q  <= sol_tus;
      onay_q <= onay_tus;
      if (iptal) begin
        durum_q   <= BOS;
        say_q     <= '0;
        gecerli_q <= 1'b0;
`ifdef ADIM_ZAMAN_ASIMI_EN
        zaman_q   <= '0;
`endif
      end else begin
        case (durum_q)
          BOS: begin
            if (herhangi_kenar) begin
              durum_q     <= A_SAG;
              say_q       <= '0;
              say_q.a_sag <= sag_kenar ? sag_art(3'd0) : 3'd0;
            end
          end
          A_SAG: begin
            if (sag_kenar)  say_q.a_sag <= sag_art(say_q.a_sag);
            if (onay_kenar) durum_q     <= A_SOL;
          end
          A_SOL: begin
            if (sol_kenar)  say_q.a_sol <= sol_art(say_q.a_sol);
            if (onay_kenar) durum_q     <= B_SAG;
          end
          B_SAG: begin
            if (sag_kenar)  say_q.b_sag <= sag_art(say_q.b_sag);
            if (onay_kenar) durum_q     <= B_SOL;
          end
          B_SOL: begin
            if (sol_kenar) say_q.b_sol <= sol_art(say_q.b_sol);
            if (onay_kenar) begin
              durum_q   <= HAZIR;
              gecerli_q <= 1'b1;
            end
          end
          HAZIR: begin
            if (onay_kenar) begin
              durum_q   <= BOS;
              say_q     <= '0;
              gecerli_q <= 1'b0;
            end
          end
          default: begin
            durum_q   <= BOS;
            say_q     <= '0;
            gecerli_q <= 1'b0;
          end
        endcase
`ifdef ADIM_ZAMAN_ASIMI_EN
        // Every state change is caused by an edge, so clearing on edges covers both.
        if (!aktif || herhangi_kenar) begin
          zaman_q <= '0;
        end else if (zaman_q == ZAMAN_SON) begin
          zaman_q   <= '0;
          durum_q   <= BOS;
          say_q     <= '0;
          gecerli_q <= 1'b0;
        end else begin
          zaman_q <= zaman_q + 20'd1;
        end
`endif
      end
    end
  end

  assign sag_adimlar = {say_q.a_sag, say_q.b_sag};
  assign sol_adimlar = {say_q.a_sol, say_q.b_sol};
  assign gecerli     = gecerli_q;
  assign asama       = durum_q;

endmodule

// File: doc/adim_toplayici.md
Name: adim_toplayici

Overview:
- Sequential front-end for the two-lock combination checker.
- Collects right-turn and left-turn dial steps for lock A, then lock B, from debounced button levels.
- Presents the packed step vectors `sag_adimlar[5:0]` and `sol_adimlar[3:0]` with a valid flag to the downstream dual-lock comparator.
- Entry order: lock A right, lock A left, lock B right, lock B left.

Parameters:
- SAG_MAX, 7, saturation value of each right-step counter; must be ≤ 7 (3-bit field).
- SOL_MAX, 3, saturation value of each left-step counter; must be ≤ 3 (2-bit field).
- ZAMAN_ASIMI, 1000000, inactivity timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sag_tus  input  1  right-step button, debounced level; one step per rising edge.
- sol_tus  input  1  left-step button, debounced level; one step per rising edge.
- onay_tus  input  1  confirm button, level; a rising edge advances to the next field.
- iptal  input  1  synchronous clear, level-sensitive, highest priority.
- sag_adimlar  output  6  [5:3] lock A right count, [2:0] lock B right count; registered.
- sol_adimlar  output  4  [3:2] lock A left count, [1:0] lock B left count; registered.
- gecerli  output  1  high when all four fields are confirmed.
- asama  output  3  current state encoding, for display and debug.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All counters = 0, gecerli = 0, state = BOS, asama = 3'd0.
  - Edge-detect registers = 0.
- Edge detection:
  - Each button is registered once; edge = level & ~level_q.
  - A level held high counts exactly once.
  - A press sampled high on cycle n updates the counters/state at the edge ending cycle n; outputs show it in cycle n+1.
- States and asama codes: BOS=0, A_SAG=1, A_SOL=2, B_SAG=3, B_SOL=4, HAZIR=5. Codes 6–7 are illegal and recover to BOS.
- BOS:
  - Any sag/sol/onay edge → A_SAG and clears all counters.
  - The triggering sag edge is also counted, so A right = 1 after one press from BOS.
- A_SAG:
  - A sag edge increments A right, saturating at SAG_MAX.
  - A sol edge is ignored.
  - An onay edge → A_SOL.
- A_SOL: a sol edge increments A left, saturating at SOL_MAX; a sag edge is ignored; onay → B_SAG.
- B_SAG: same rules as A_SAG, on the B right field; onay → B_SOL.
- B_SOL: same rules as A_SOL, on the B left field; onay → HAZIR.
- HAZIR:
  - gecerli = 1, counters frozen.
  - sag/sol edges are ignored.
  - An onay edge → BOS with counters cleared and gecerli = 0, ready for a new attempt.
- Simultaneous events in one cycle:
  - iptal overrides everything: state → BOS, counters = 0, gecerli = 0.
  - A step edge together with an onay edge: the step is counted into the current field and the state advances on the same edge.
  - sag and sol edges together: only the edge matching the current field is counted.
- gecerli:
  - Registered; rises in the cycle after the B_SOL onay edge.
  - Stays high while in HAZIR; falls on leaving HAZIR.
- Counters saturate and never wrap.
- Outputs are driven continuously in all states. Downstream logic must qualify them with gecerli.

Optional Feature:
- Macro: ADIM_ZAMAN_ASIMI_EN.
- Defined:
  - A 20-bit inactivity counter runs in states A_SAG through B_SOL.
  - It clears on any sag/sol/onay edge or on a state change.
  - On reaching ZAMAN_ASIMI−1, the next edge forces BOS, clears all counters and sets gecerli = 0.
  - The counter does not run in BOS or HAZIR.
  - iptal still has priority.
- Undefined: no timer logic; the block waits indefinitely in any state.

Test Plan:
- Basic entry: reset, then sag×5, onay, sol×2, onay, sag×3, onay, sol×1, onay → sag_adimlar = 6'b101011, sol_adimlar = 4'b1001, gecerli = 1 one cycle after the last onay edge, asama = 5.
- Saturation: sag×10 in A_SAG and sol×6 in A_SOL → A right = 7, A left = 3; no wrap to 0.
- Held button and cross input: sag held high for 20 cycles counts as 1; sol edges in A_SAG leave sol_adimlar = 0.
- Simultaneous events: a sag edge and an onay edge in the same cycle in B_SAG → B right incremented and asama = 4. iptal together with onay in B_SOL → asama = 0, all outputs 0.
- Reset mid-operation: rst_n pulled low asynchronously in B_SAG with a nonzero count → outputs 0 immediately, without waiting for clk. The first sag edge after release → asama = 1, A right = 1.
- Timeout (with ADIM_ZAMAN_ASIMI_EN, ZAMAN_ASIMI = 16): in A_SOL, 16 idle cycles → BOS with counters cleared. With an edge at cycle 15 → the timer restarts and the state is retained.
